// File: rtl/mem_port_pkg.sv
// mem_port_pkg: shared state encoding, default widths and size-to-mask helper. Rev 1.0
`default_nettype none
package mem_port_pkg;

  localparam int unsigned DEF_ADDR_W = 7;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_SIZE_W = 4;
  localparam int unsigned MASK_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Equivalent to (1<<size)-1, saturating to all ones once size reaches the lane width.
  function automatic logic [MASK_MAX_W-1:0] size_to_mask(input int unsigned size,
                                                         input int unsigned width);
    logic [MASK_MAX_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_MAX_W; i++) begin
      if ((i < size) && (i < width)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_watchdog.sv
// mem_port_watchdog: access-duration counter, flags expiry on the TIMEOUT-th busy cycle. Rev 1.0
`default_nettype none
module mem_port_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count_q;

  assign expired = run && (count_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (run && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_initiator.sv
// mem_port_initiator: single-outstanding core-to-RAM initiator FSM. Rev 1.0
// Define MEM_PORT_TIMEOUT_EN to add the access watchdog and rsp_err reporting.
`default_nettype none
module mem_port_initiator
  import mem_port_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned SIZE_W  = DEF_SIZE_W,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [SIZE_W-1:0] req_size,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              Mout_oe_ram,
  output logic              Mout_we_ram,
  output logic [ADDR_W-1:0] Mout_addr_ram,
  output logic [DATA_W-1:0] Mout_Wdata_ram,
  output logic [SIZE_W-1:0] Mout_data_ram_size,
  input  logic [DATA_W-1:0] M_Rdata_ram,
  input  logic              M_DataRdy
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] mask;
  logic              busy, accept, expired;

  assign busy      = (state_q == ST_READ) || (state_q == ST_WRITE);
  assign req_ready = (state_q == ST_IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign mask      = DATA_W'(size_to_mask(32'(size_q), DATA_W));

`ifdef MEM_PORT_TIMEOUT_EN
  mem_port_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (accept),
    .run     (busy),
    .expired (expired)
  );
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign expired        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          rdata_d = '0;
          err_d   = 1'b0;
          if (req_size == '0)  state_d = ST_RESP;
          else if (req_we)     state_d = ST_WRITE;
          else                 state_d = ST_READ;
        end
      end
      ST_READ, ST_WRITE: begin
        // A completion arriving on the watchdog's last cycle takes priority over expiry.
        if (M_DataRdy) begin
          state_d = ST_RESP;
          rdata_d = (state_q == ST_READ) ? (M_Rdata_ram & mask) : '0;
          err_d   = 1'b0;
        end else if (expired) begin
          state_d = ST_RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign Mout_oe_ram        = (state_q == ST_READ);
  assign Mout_we_ram        = (state_q == ST_WRITE);
  assign Mout_addr_ram      = busy ? addr_q  : '0;
  assign Mout_Wdata_ram     = busy ? wdata_q : '0;
  assign Mout_data_ram_size = busy ? size_q  : '0;
  assign rsp_valid          = (state_q == ST_RESP);
  assign rsp_rdata          = rsp_valid ? rdata_q : '0;
  assign rsp_err            = rsp_valid && err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_initiator.sv
// tb_mem_port_initiator: scoreboard bench with a delay-programmable RAM responder.
`default_nettype none
module tb_mem_port_initiator;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic [3:0] req_size = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       Mout_oe_ram, Mout_we_ram;
  logic [6:0] Mout_addr_ram;
  logic [7:0] Mout_Wdata_ram;
  logic [3:0] Mout_data_ram_size;
  logic [7:0] M_Rdata_ram = '0;
  logic       M_DataRdy = 1'b0;

  mem_port_initiator #(
    .ADDR_W (7), .DATA_W (8), .SIZE_W (4), .TIMEOUT (8)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_we             (req_we),
    .req_addr           (req_addr),
    .req_wdata          (req_wdata),
    .req_size           (req_size),
    .rsp_valid          (rsp_valid),
    .rsp_rdata          (rsp_rdata),
    .rsp_err            (rsp_err),
    .Mout_oe_ram        (Mout_oe_ram),
    .Mout_we_ram        (Mout_we_ram),
    .Mout_addr_ram      (Mout_addr_ram),
    .Mout_Wdata_ram     (Mout_Wdata_ram),
    .Mout_data_ram_size (Mout_data_ram_size),
    .M_Rdata_ram        (M_Rdata_ram),
    .M_DataRdy          (M_DataRdy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] rd;
    logic       er;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] mem [128];
  int         rd_delay = 2;     // 0: responder never answers
  int         strobe_cnt = 0;
  logic       stray_rdy = 1'b0; // DataRdy driven while no access is open

  // Responder: DataRdy on the rd_delay-th strobe cycle.
  always @(negedge clock) begin
    if (Mout_oe_ram || Mout_we_ram) begin
      strobe_cnt  = strobe_cnt + 1;
      M_DataRdy   = (rd_delay != 0) && (strobe_cnt == rd_delay);
      M_Rdata_ram = mem[Mout_addr_ram];
    end else begin
      strobe_cnt  = 0;
      M_DataRdy   = stray_rdy;
      M_Rdata_ram = 8'hEE;
    end
  end

  // Scoreboard and protocol invariants.
  always @(negedge clock) begin
    total++;
    if (Mout_oe_ram && Mout_we_ram) begin
      bad++; $display("FAIL oe_we_exclusive: oe=%b we=%b required not both", Mout_oe_ram, Mout_we_ram);
    end
    if (Mout_oe_ram || Mout_we_ram) begin
      total++;
      if (req_ready !== 1'b0) begin
        bad++; $display("FAIL ready_while_busy: req_ready=%b required 0", req_ready);
      end
    end else begin
      total++;
      if ({Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size} !== 19'd0) begin
        bad++; $display("FAIL idle_bus_zero: addr=%h wdata=%h size=%h required 0",
                        Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size);
      end
    end
    if (rsp_valid === 1'b1) begin
      exp_t e;
      total++;
      if (sb.size() == 0) begin
        bad++; $display("FAIL unexpected_rsp: rsp_valid=1 rdata=%h with no request pending", rsp_rdata);
      end else begin
        e = sb.pop_front();
        if (rsp_rdata !== e.rd || rsp_err !== e.er) begin
          bad++; $display("FAIL rsp_data: rdata=%h err=%b required rdata=%h err=%b",
                          rsp_rdata, rsp_err, e.rd, e.er);
        end
      end
    end
  end

  function automatic logic [7:0] model_rd(input logic [7:0] v, input logic [3:0] sz);
    logic [7:0] one;
    one = 8'd1;
    if (sz >= 4'd8) return v;
    return v & ((one << sz) - 8'd1);
  endfunction

  // Drives one request (caller at a negedge) and watches it to completion.
  task automatic issue(input logic we, input logic [6:0] addr, input logic [7:0] wd,
                       input logic [3:0] sz, input logic [7:0] exp_rd, input logic exp_er,
                       output int oe_cyc, output int we_cyc, output int lat,
                       output int bus_bad, output bit timed_out);
    int guard;
    oe_cyc = 0; we_cyc = 0; lat = 1; bus_bad = 0; timed_out = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_size = sz;
    sb.push_back('{rd: exp_rd, er: exp_er});
    guard = 0;
    while (req_ready !== 1'b1 && guard < 50) begin
      @(negedge clock); guard++;
    end
    guard = 0;
    do begin
      @(negedge clock);
      req_valid = 1'b0;
      lat++; guard++;
      if (Mout_oe_ram) oe_cyc++;
      if (Mout_we_ram) we_cyc++;
      if ((Mout_oe_ram || Mout_we_ram) &&
          (Mout_addr_ram !== addr || Mout_Wdata_ram !== wd || Mout_data_ram_size !== sz))
        bus_bad++;
    end while (rsp_valid !== 1'b1 && guard < 100);
    if (rsp_valid !== 1'b1) timed_out = 1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    total++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata, Mout_oe_ram, Mout_we_ram,
         Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size} !== 33'd0) begin
      bad++; $display("FAIL reset_outputs: ready=%b rv=%b err=%b rd=%h oe=%b we=%b required all 0",
                      req_ready, rsp_valid, rsp_err, rsp_rdata, Mout_oe_ram, Mout_we_ram);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL ready_after_reset: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_read();
    int oe_c, we_c, lat, bb; bit to;
    rd_delay = 2;
    mem[5] = 8'hA7;
    issue(1'b0, 7'h05, 8'h00, 4'd8, 8'hA7, 1'b0, oe_c, we_c, lat, bb, to);
    total++;
    if (oe_c !== 2 || we_c !== 0 || lat !== 4 || bb !== 0 || to) begin
      bad++; $display("FAIL read_basic: oe=%0d we=%0d lat=%0d busbad=%0d to=%0d required 2 0 4 0 0",
                      oe_c, we_c, lat, bb, to);
    end
  endtask

  task automatic test_write_mask();
    int oe_c, we_c, lat, bb; bit to;
    rd_delay = 1;
    issue(1'b1, 7'h10, 8'h3C, 4'd4, 8'h00, 1'b0, oe_c, we_c, lat, bb, to);
    total++;
    if (we_c !== 1 || oe_c !== 0 || lat !== 3 || bb !== 0 || to) begin
      bad++; $display("FAIL write_basic: we=%0d oe=%0d lat=%0d busbad=%0d to=%0d required 1 0 3 0 0",
                      we_c, oe_c, lat, bb, to);
    end
    mem[7'h20] = 8'hFF;
    issue(1'b0, 7'h20, 8'h00, 4'd4, 8'h0F, 1'b0, oe_c, we_c, lat, bb, to);
    total++;
    if (oe_c !== 1 || lat !== 3 || to) begin
      bad++; $display("FAIL read_size4: oe=%0d lat=%0d to=%0d required 1 3 0", oe_c, lat, to);
    end
    issue(1'b0, 7'h20, 8'h00, 4'd12, 8'hFF, 1'b0, oe_c, we_c, lat, bb, to);
    total++;
    if (oe_c !== 1 || to) begin
      bad++; $display("FAIL read_size_wide: oe=%0d to=%0d required 1 0", oe_c, to);
    end
    mem[7'h21] = 8'hB6;
    issue(1'b0, 7'h21, 8'h00, 4'd1, 8'h00, 1'b0, oe_c, we_c, lat, bb, to);
    total++;
    if (oe_c !== 1 || to) begin
      bad++; $display("FAIL read_size1: oe=%0d to=%0d required 1 0", oe_c, to);
    end
  endtask

  task automatic test_size_zero();
    int oe_c, we_c, lat, bb; bit to;
    rd_delay = 2;
    issue(1'b0, 7'h05, 8'h00, 4'd0, 8'h00, 1'b0, oe_c, we_c, lat, bb, to);
    total++;
    if (oe_c !== 0 || we_c !== 0 || lat !== 2 || to) begin
      bad++; $display("FAIL size_zero: oe=%0d we=%0d lat=%0d to=%0d required 0 0 2 0",
                      oe_c, we_c, lat, to);
    end
  endtask

  task automatic test_reset_abort();
    int guard, rv_seen, oe_seen;
    rd_delay = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 7'h33; req_size = 4'd8;
    guard = 0;
    while (Mout_oe_ram !== 1'b1 && guard < 20) begin
      @(negedge clock); guard++;
      if (req_ready !== 1'b1) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    total++;
    if (Mout_oe_ram !== 1'b1) begin
      bad++; $display("FAIL abort_oe_rise: oe=%b required 1", Mout_oe_ram);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    total++;
    if (Mout_oe_ram !== 1'b0 || req_ready !== 1'b0) begin
      bad++; $display("FAIL abort_oe_drop: oe=%b ready=%b required 0 0", Mout_oe_ram, req_ready);
    end
    reset = 1'b0;
    stray_rdy = 1'b1;
    @(negedge clock);
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL abort_ready: req_ready=%b required 1", req_ready);
    end
    rv_seen = 0; oe_seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (rsp_valid === 1'b1) rv_seen++;
      if (Mout_oe_ram === 1'b1 || req_ready !== 1'b1) oe_seen++;
    end
    stray_rdy = 1'b0;
    total++;
    if (rv_seen !== 0 || oe_seen !== 0) begin
      bad++; $display("FAIL abort_no_reissue: rsp=%0d busy=%0d required 0 0", rv_seen, oe_seen);
    end
  endtask

`ifdef MEM_PORT_TIMEOUT_EN
  task automatic test_timeout();
    int oe_c, we_c, lat, bb; bit to;
    rd_delay = 0;
    issue(1'b0, 7'h05, 8'h00, 4'd8, 8'h00, 1'b1, oe_c, we_c, lat, bb, to);
    total++;
    if (oe_c !== 8 || lat !== 10 || to) begin
      bad++; $display("FAIL timeout_expire: oe=%0d lat=%0d to=%0d required 8 10 0", oe_c, lat, to);
    end
    rd_delay = 8;
    issue(1'b0, 7'h05, 8'h00, 4'd8, mem[5], 1'b0, oe_c, we_c, lat, bb, to);
    total++;
    if (oe_c !== 8 || lat !== 10 || to) begin
      bad++; $display("FAIL timeout_race: oe=%0d lat=%0d to=%0d required 8 10 0", oe_c, lat, to);
    end
  endtask
`endif

  task automatic test_back_to_back();
    int oe_c, we_c, lat, bb, bb_total, to_total; bit to;
    logic we; logic [6:0] a; logic [7:0] wd; logic [3:0] sz; logic [7:0] e;
    bb_total = 0; to_total = 0;
    for (int n = 0; n < 24; n++) begin
      rd_delay = int'($urandom_range(1, 3));
      we = 1'($urandom_range(0, 1));
      a  = 7'($urandom_range(0, 127));
      wd = 8'($urandom_range(0, 255));
      sz = 4'($urandom_range(0, 10));
      e  = (we || sz == 4'd0) ? 8'h00 : model_rd(mem[a], sz);
      issue(we, a, wd, sz, e, 1'b0, oe_c, we_c, lat, bb, to);
      bb_total += bb;
      if (to) to_total++;
    end
    total++;
    if (bb_total !== 0 || to_total !== 0) begin
      bad++; $display("FAIL b2b_stability: busbad=%0d timeouts=%0d required 0 0", bb_total, to_total);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'(i * 37 + 11);
    test_reset();
    test_read();
    test_write_mask();
    test_size_zero();
    test_reset_abort();
`ifdef MEM_PORT_TIMEOUT_EN
    test_timeout();
`endif
    test_back_to_back();
    repeat (3) @(negedge clock);
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_drain: pending=%0d required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_initiator.md
MEM_PORT_INITIATOR -- requirements
Module: mem_port_initiator

Interface
REQ-001 SHALL have parameters: ADDR_W, default 7, bus address width; DATA_W, default 8, data lane width; SIZE_W, default 4, access-size field width; TIMEOUT, default 64, watchdog limit in cycles.
REQ-002 SHALL have port clock  input  1  the only clock; all logic samples on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  core request present.
REQ-005 SHALL have port req_ready  output  1  request accepted when req_valid and req_ready are both high.
REQ-006 SHALL have ports req_we  input  1, req_addr  input  ADDR_W, req_wdata  input  DATA_W, req_size  input  SIZE_W: write flag, address, write data and access size in bits.
REQ-007 SHALL have ports rsp_valid  output  1, rsp_rdata  output  DATA_W, rsp_err  output  1: one-cycle completion pulse, masked read data and timeout flag.
REQ-008 SHALL have ports Mout_oe_ram  output  1, Mout_we_ram  output  1, Mout_addr_ram  output  ADDR_W, Mout_Wdata_ram  output  DATA_W, Mout_data_ram_size  output  SIZE_W: the bus-side read strobe, write strobe, address, write data and size.
REQ-009 SHALL have ports M_Rdata_ram  input  DATA_W, M_DataRdy  input  1: responder read data and completion.

Function
REQ-010 SHALL implement FSM states IDLE, READ, WRITE and RESP; req_ready SHALL be high only in IDLE.
REQ-011 Accept in IDLE SHALL register addr, wdata and size, then go to READ (req_we=0) or WRITE (req_we=1); strobes SHALL rise on the next cycle after accept.
REQ-012 In READ, Mout_oe_ram SHALL be 1; in WRITE, Mout_we_ram SHALL be 1; oe and we SHALL never be high together.
REQ-013 Addr, Wdata and size outputs SHALL hold stable for the whole access; outside READ and WRITE they SHALL be 0.
REQ-014 The FSM SHALL sample M_DataRdy=1 in READ or WRITE, drop the strobe next cycle and enter RESP; in READ the same edge SHALL capture M_Rdata_ram AND mask into rsp_rdata.
REQ-015 mask SHALL be (1<<size)-1; when size >= DATA_W, mask SHALL be all ones.
REQ-016 RESP SHALL drive rsp_valid=1 for exactly one cycle, then return to IDLE; write responses SHALL return rsp_rdata=0.
REQ-017 A request with req_size=0 SHALL skip the bus entirely: IDLE->RESP, rsp_rdata=0, rsp_err=0.
REQ-018 Minimum request-to-rsp_valid latency SHALL be DataRdy delay + 2 cycles: 4 cycles against a 2-cycle read responder.
REQ-019 M_DataRdy outside READ or WRITE SHALL be ignored.

Reset
REQ-020 On reset=1 at a clock edge: state=IDLE; req_ready, rsp_valid, rsp_err, rsp_rdata and all Mout_* SHALL be 0 on the following cycle.
REQ-021 Reset mid-access SHALL abort with no rsp_valid; the dropped transaction SHALL never be reissued.
REQ-022 During reset, req_ready SHALL read 0.

Configuration
REQ-023 With MEM_PORT_TIMEOUT_EN defined, a counter SHALL clear on entry to READ or WRITE and increment each cycle there.
REQ-024 With MEM_PORT_TIMEOUT_EN defined, when the count reaches TIMEOUT-1 without M_DataRdy, the FSM SHALL drop the strobe, enter RESP with rsp_err=1 and return rsp_rdata=0.
REQ-025 With MEM_PORT_TIMEOUT_EN defined, M_DataRdy in the same cycle as the limit SHALL win, giving rsp_err=0.
REQ-026 Without MEM_PORT_TIMEOUT_EN, the counter SHALL not exist, the FSM SHALL wait indefinitely, and rsp_err SHALL be constant 0.

Structure
REQ-027 The shared package mem_port_pkg SHALL hold the FSM state enum, default ADDR_W, DATA_W and SIZE_W constants, and the size-to-mask function.
REQ-028 The watchdog SHALL be the sub-module mem_port_watchdog (inputs clear and run; output expired), instantiated only under MEM_PORT_TIMEOUT_EN.

Verification
REQ-029 Bench: read addr 0x05, size 8, responder preloaded with 0xA7, 2-cycle delay -> oe high for 2 cycles, rsp_valid on cycle 4, rsp_rdata=0xA7, rsp_err=0.
REQ-030 Bench: write addr 0x10, wdata 0x3C, size 4, 1-cycle responder -> we high 1 cycle, Mout_Wdata_ram=0x3C, Mout_data_ram_size=4, rsp_valid with rdata 0; then read size 4 of memory 0xFF -> rsp_rdata=0x0F.
REQ-031 Bench: req_size=0 read -> no oe, rsp_valid 2 cycles after accept with rdata 0.
REQ-032 Bench: reset asserted the cycle after oe rises -> oe=0 next cycle, no rsp_valid, req_ready=1 after reset releases.
REQ-033 Bench (MEM_PORT_TIMEOUT_EN, TIMEOUT=8): responder never answers -> oe high 8 cycles, rsp_valid with rsp_err=1; repeat with DataRdy on cycle 8 -> rsp_err=0.
REQ-034 Bench: random back-to-back requests -> oe and we never both high, req_ready=0 while busy, addr stable per access.
